// File: rtl/circuit_pkg.sv
// ----------------------------------------------------------------------------
// circuit_pkg
// Shared definitions for the exhaustive-sweep controller: default vector and
// signature widths, MISR polynomial and seed, and the controller state enum.
// ----------------------------------------------------------------------------
package circuit_pkg;

  localparam int unsigned W     = 5;   // circuit input/output vector width
  localparam int unsigned SIG_W = 16;  // signature register width

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_misr.sv
// ----------------------------------------------------------------------------
// sweep_misr
// Multiple-input signature register. Each enabled cycle shifts the signature
// left, folds in POLY when the outgoing MSB was set, and XORs in the
// zero-extended data word.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, loads RST_VAL
//   seed   in   SIG_W value loaded when load=1
//   load   in   reload signature from seed (priority over en)
//   en     in   absorb data this cycle
//   data   in   DATA_W word to compress
//   sig    out  SIG_W current signature
// ----------------------------------------------------------------------------
module sweep_misr #(
  parameter int unsigned       SIG_W   = circuit_pkg::SIG_W,
  parameter int unsigned       DATA_W  = circuit_pkg::W,
  parameter logic [SIG_W-1:0]  POLY    = SIG_W'(circuit_pkg::MISR_POLY),
  parameter logic [SIG_W-1:0]  RST_VAL = SIG_W'(circuit_pkg::SIG_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIG_W-1:0]  seed,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  always_comb begin
    w_next = {r_sig[SIG_W-2:0], 1'b0};
    if (r_sig[SIG_W-1]) begin
      w_next = w_next ^ POLY;
    end
    w_next = w_next ^ SIG_W'(data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= RST_VAL;
    end else if (load) begin
      r_sig <= seed;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// circuit_sweep_ctrl
// Drives every vector from lo to hi (wrapping modulo 2^W) into a
// combinational circuit, gives the circuit one full cycle to settle, then
// samples its response into a MISR signature plus vector/hit counters.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   sweep request, honoured only in IDLE
//   abort      in   stop a sweep in progress (DRIVE/SAMPLE)
//   lo, hi     in   W  first/last vector, sampled at start acceptance
//   dut_in     out  W  registered vector to the circuit
//   dut_out    in   W  circuit response to dut_in
//   busy       out  high in DRIVE and SAMPLE
//   done       out  one-cycle completion pulse (DONE state)
//   signature  out  SIG_W MISR over sampled responses
//   vec_cnt    out  W+1 vectors sampled
//   hit_cnt    out  W+1 sampled responses that were non-zero
// ----------------------------------------------------------------------------
module circuit_sweep_ctrl #(
  parameter int unsigned W     = circuit_pkg::W,
  parameter int unsigned SIG_W = circuit_pkg::SIG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  output logic [W-1:0]     dut_in,
  input  logic [W-1:0]     dut_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [W:0]       vec_cnt,
  output logic [W:0]       hit_cnt
);

  import circuit_pkg::*;

  localparam logic [W:0]   CNT_ONE = (W+1)'(1);
  localparam logic [W-1:0] VEC_ONE = W'(1);

  state_t       r_state;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_dut_in;
  logic         r_busy;
  logic         r_done;
  logic [W:0]   r_vec_cnt;
  logic [W:0]   r_hit_cnt;

  logic         w_start_acc;
  logic         w_sample;
  logic         w_last;
  logic [SIG_W-1:0] w_sig;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_sample    = (r_state == SAMPLE);
  assign w_last      = (r_dut_in == r_hi);

  // The in-flight sample still completes when abort arrives in SAMPLE;
  // abort only suppresses the advance to the next vector and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hi      <= '0;
      r_dut_in  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vec_cnt <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_hi      <= hi;
            r_dut_in  <= lo;
            r_vec_cnt <= '0;
            r_hit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_vec_cnt <= r_vec_cnt + CNT_ONE;
          if (dut_out != '0) begin
            r_hit_cnt <= r_hit_cnt + CNT_ONE;
          end
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_dut_in <= r_dut_in + VEC_ONE;
            r_state  <= DRIVE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  sweep_misr #(
    .SIG_W   (SIG_W),
    .DATA_W  (W),
    .POLY    (SIG_W'(MISR_POLY)),
    .RST_VAL (SIG_W'(SIG_SEED))
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SIG_W'(SIG_SEED)),
    .load  (w_start_acc),
    .en    (w_sample),
    .data  (dut_out),
    .sig   (w_sig)
  );

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = w_sig;
  assign vec_cnt   = r_vec_cnt;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: doc/circuit_sweep_ctrl.md
CIRCUIT_SWEEP_CTRL -- requirements
Module: circuit_sweep_ctrl

Interface
REQ-001 Parameter W, default 5: width of the circuit input/output vector.
REQ-002 Parameter SIG_W, default 16: signature register width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  sweep request; accepted only in IDLE.
REQ-006 abort  input  1  terminate sweep in progress.
REQ-007 lo  input  W  first vector of the sweep, sampled at start acceptance.
REQ-008 hi  input  W  last vector of the sweep, sampled at start acceptance.
REQ-009 dut_in  output  W  registered vector driven to the circuit's in port.
REQ-010 dut_out  input  W  the circuit's out port (combinational response to dut_in).
REQ-011 busy  output  1  high in DRIVE and SAMPLE.
REQ-012 done  output  1  single-cycle pulse on sweep completion.
REQ-013 signature  output  SIG_W  MISR over all sampled dut_out values.
REQ-014 vec_cnt  output  W+1  number of vectors sampled.
REQ-015 hit_cnt  output  W+1  number of sampled vectors with dut_out != 0.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE.
REQ-017 In IDLE, start=1 SHALL latch lo/hi, set dut_in=lo, seed signature to SIG_SEED (16'hFFFF), clear vec_cnt and hit_cnt, and go to DRIVE.
REQ-018 DRIVE SHALL last one cycle and hold dut_in, then go to SAMPLE.
REQ-019 In SAMPLE, the block SHALL capture dut_out: signature <= {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ zero-extended dut_out, with MISR_POLY=16'h1021; vec_cnt += 1; hit_cnt += 1 if dut_out != 0.
REQ-020 From SAMPLE, if dut_in == latched hi the FSM SHALL go to DONE, else dut_in SHALL increment modulo 2^W and the FSM SHALL go to DRIVE.
REQ-021 lo > hi SHALL wrap: lo..2^W-1, then 0..hi; lo == hi SHALL sweep exactly one vector.
REQ-022 DONE SHALL assert done for exactly one cycle, with busy=0, and then go to IDLE.
REQ-023 Latency: for N vectors, done SHALL be high on the (2N+1)th cycle after the start-accept edge.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 abort in DRIVE or SAMPLE SHALL return the FSM to IDLE at the next edge with no done pulse, and SHALL hold partial results and dut_in; abort wins over a simultaneous final SAMPLE.
REQ-026 signature, vec_cnt, hit_cnt and dut_in SHALL hold stable in IDLE until the next accepted start.
REQ-027 dut_out SHALL be sampled only in SAMPLE, so the circuit gets one full cycle to settle.

Reset
REQ-028 rst_n low SHALL force, asynchronously: state=IDLE, dut_in=0, busy=0, done=0, signature=SIG_SEED, vec_cnt=0, hit_cnt=0, latched lo/hi=0.
REQ-029 Reset during a sweep SHALL abandon the sweep; the first start after release SHALL behave per REQ-017.

Structure
REQ-030 Shared package circuit_pkg SHALL hold W, SIG_W, MISR_POLY, SIG_SEED and the FSM state enum.
REQ-031 The MISR update SHALL be a sub-module sweep_misr (inputs: clk, rst_n, seed, en, data; output: sig).
REQ-032 Target size: 120-400 lines of RTL, no memories.

Verification
REQ-033 lo=0, hi=31, dut_out=dut_in loopback -> dut_in steps 0..31, vec_cnt=32, hit_cnt=31, done on cycle 65 after start accept.
REQ-034 lo=hi=0, dut_out tied 0 -> vec_cnt=1, hit_cnt=0, signature=16'hEFDF, done on cycle 3.
REQ-035 lo=30, hi=1, loopback -> dut_in sequence 30,31,0,1, vec_cnt=4, hit_cnt=3.
REQ-036 lo=0, hi=31, abort on cycle 10 -> IDLE next cycle, busy=0, no done, vec_cnt=5; a following start runs a full sweep.
REQ-037 start pulsed while busy -> no restart, counts unchanged; rst_n low mid-sweep -> all outputs at REQ-028 values immediately.
REQ-038 Bench SHALL instantiate the real circuit module as the DUT load and compare signature against a reference model.
